pipeline_pc_ctrl: RTL and testbench

- Next-PC source controller and fetch sequencer for the 5-stage pipeline; drives PCSrc and stall into the IF stage, and flush strobes into the IF/ID and ID/EX registers.
- Arbitrates the control-transfer requesters: load-use hazard, jumps and branches decoded in ID, exceptions, external interrupt and eret.
- Owns the interrupt/exception FSM and the EPC register.

---
 rtl/pipeline_pc_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipeline_pc_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_pc_ctrl.sv
// Next-PC source selection, load-use stall sequencing and interrupt/exception
// entry for the 5-stage pipeline. The controller also owns the EPC register.
module pipeline_pc_ctrl #(
    parameter int STALL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Irq,
    input  logic        Exc,
    input  logic        Eret,
    input  logic        LoadUse,
    input  logic        ID_Branch,
    input  logic        BranchTaken,
    input  logic        ID_Jump,
    input  logic        ID_JR,
    input  logic        PC_Kernel,
    input  logic [31:0] ID_PC,
    output logic [2:0]  PCSrc,
    output logic        Stall,
    output logic        IF_Flush,
    output logic        ID_Flush,
    output logic [31:0] EPC,
    output logic        EPC_we,
    output logic        IrqMasked
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        IRQ_WAIT = 2'd1,
        KERNEL   = 2'd2
    } state_t;

    localparam logic [2:0] PC_SEQ    = 3'd0;
    localparam logic [2:0] PC_BRANCH = 3'd1;
    localparam logic [2:0] PC_JUMP   = 3'd2;
    localparam logic [2:0] PC_REG    = 3'd3;
    localparam logic [2:0] PC_IRQ    = 3'd4;
    localparam logic [2:0] PC_EXC    = 3'd5;

    localparam logic [2:0] STALL_LOAD = 3'(STALL_CYCLES - 1);

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic [31:0] epc_nxt;

    logic in_kernel;
    logic cnt_busy;
    logic stall_req;
    logic cf_req;
    logic exc_take;
    logic irq_take;

    assign in_kernel = (state == KERNEL);
    assign cnt_busy  = (cnt != 3'd0);
    // A running stall count swallows LoadUse; a fresh LoadUse starts a new stall.
    assign stall_req = cnt_busy || LoadUse;
    assign cf_req    = ID_Branch || ID_Jump || ID_JR;
    assign exc_take  = !in_kernel && Exc && !PC_Kernel;
    assign irq_take  = !in_kernel && Irq && !PC_Kernel && !stall_req && !cf_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= 3'd0;
            EPC   <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            EPC   <= epc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        epc_nxt   = EPC;
        PCSrc     = PC_SEQ;
        Stall     = 1'b0;
        IF_Flush  = 1'b0;
        ID_Flush  = 1'b0;
        EPC_we    = 1'b0;
        IrqMasked = in_kernel;

        if (exc_take) begin
            cnt_nxt = 3'd0;
        end else if (cnt_busy) begin
            cnt_nxt = cnt - 3'd1;
        end else if (LoadUse) begin
            cnt_nxt = STALL_LOAD;
        end else begin
            cnt_nxt = 3'd0;
        end

        if (!in_kernel) begin
            state_nxt = Irq ? IRQ_WAIT : RUN;
        end

        if (exc_take) begin
            PCSrc     = PC_EXC;
            IF_Flush  = 1'b1;
            ID_Flush  = 1'b1;
            EPC_we    = 1'b1;
            epc_nxt   = ID_PC + 32'd4;
            state_nxt = KERNEL;
        end else if (irq_take) begin
            // The flushed instruction in ID is replayed after eret.
            PCSrc     = PC_IRQ;
            IF_Flush  = 1'b1;
            ID_Flush  = 1'b1;
            EPC_we    = 1'b1;
            epc_nxt   = ID_PC;
            state_nxt = KERNEL;
        end else if (stall_req) begin
            Stall     = 1'b1;
            ID_Flush  = 1'b1;
        end else if (in_kernel && Eret) begin
            PCSrc     = PC_REG;
            IF_Flush  = 1'b1;
            state_nxt = RUN;
        end else if (ID_JR) begin
            PCSrc     = PC_REG;
            IF_Flush  = 1'b1;
        end else if (ID_Jump) begin
            PCSrc     = PC_JUMP;
            IF_Flush  = 1'b1;
        end else if (ID_Branch) begin
            PCSrc     = PC_BRANCH;
            IF_Flush  = BranchTaken;
        end

        if (reset) begin
            PCSrc     = PC_SEQ;
            Stall     = 1'b0;
            IF_Flush  = 1'b0;
            ID_Flush  = 1'b0;
            EPC_we    = 1'b0;
            IrqMasked = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipeline_pc_ctrl.sv
// Bench for pipeline_pc_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a deadline-based behavioural model.
module tb_pipeline_pc_ctrl;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset, Irq, Exc, Eret, LoadUse, ID_Branch, BranchTaken;
    logic        ID_Jump, ID_JR, PC_Kernel;
    logic [31:0] ID_PC;
    logic [2:0]  PCSrc;
    logic        Stall, IF_Flush, ID_Flush, EPC_we, IrqMasked;
    logic [31:0] EPC;

    int checks = 0;
    int errors = 0;

    // Model state: privilege mode, saved EPC, and the cycle on which the
    // current stall window ends (stalled while cyc < stall_end).
    bit          m_kernel;
    logic [31:0] m_epc;
    int          cyc;
    int          stall_end;

    always #5 clk = ~clk;

    pipeline_pc_ctrl #(.STALL_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .Irq(Irq), .Exc(Exc), .Eret(Eret),
        .LoadUse(LoadUse), .ID_Branch(ID_Branch), .BranchTaken(BranchTaken),
        .ID_Jump(ID_Jump), .ID_JR(ID_JR), .PC_Kernel(PC_Kernel), .ID_PC(ID_PC),
        .PCSrc(PCSrc), .Stall(Stall), .IF_Flush(IF_Flush), .ID_Flush(ID_Flush),
        .EPC(EPC), .EPC_we(EPC_we), .IrqMasked(IrqMasked)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic idle();
        Irq = 0; Exc = 0; Eret = 0; LoadUse = 0; ID_Branch = 0; BranchTaken = 0;
        ID_Jump = 0; ID_JR = 0; PC_Kernel = 0; ID_PC = 32'h0;
    endtask

    // One clock: compare outputs mid-cycle against the model, then advance it.
    task automatic step();
        logic [2:0]  e_pc;
        logic        e_st, e_iff, e_idf, e_we;
        logic [31:0] n_epc;
        bit          n_k, busy, stalled, exc, irq;
        int          n_se;
        @(negedge clk);
        e_pc = 0; e_st = 0; e_iff = 0; e_idf = 0; e_we = 0;
        n_k = m_kernel; n_epc = m_epc; n_se = stall_end;
        busy    = (cyc < stall_end);
        stalled = busy || LoadUse;
        exc = !m_kernel && Exc && !PC_Kernel;
        irq = !m_kernel && Irq && !PC_Kernel && !stalled && !ID_Branch && !ID_Jump && !ID_JR;
        if (exc) begin
            e_pc = 5; e_iff = 1; e_idf = 1; e_we = 1;
            n_epc = ID_PC + 32'd4; n_k = 1; n_se = 0;
        end else if (irq) begin
            e_pc = 4; e_iff = 1; e_idf = 1; e_we = 1;
            n_epc = ID_PC; n_k = 1;
        end else if (stalled) begin
            e_st = 1; e_idf = 1;
            if (!busy) n_se = cyc + S;
        end else if (m_kernel && Eret) begin
            e_pc = 3; e_iff = 1; n_k = 0;
        end else if (ID_JR) begin
            e_pc = 3; e_iff = 1;
        end else if (ID_Jump) begin
            e_pc = 2; e_iff = 1;
        end else if (ID_Branch) begin
            e_pc = 1; e_iff = BranchTaken;
        end
        if (!reset) begin
            chk("PCSrc", 32'(PCSrc), 32'(e_pc));
            chk("Stall", 32'(Stall), 32'(e_st));
            chk("IF_Flush", 32'(IF_Flush), 32'(e_iff));
            chk("ID_Flush", 32'(ID_Flush), 32'(e_idf));
            chk("EPC_we", 32'(EPC_we), 32'(e_we));
            chk("EPC", EPC, m_epc);
            chk("IrqMasked", 32'(IrqMasked), 32'(m_kernel));
        end
        @(posedge clk);
        if (reset) begin
            m_kernel = 0; m_epc = 32'h0; stall_end = 0;
        end else begin
            m_kernel = n_k; m_epc = n_epc; stall_end = n_se;
        end
        cyc++;
        #1;
    endtask

    initial begin
        m_kernel = 0; m_epc = 32'h0; cyc = 0; stall_end = 0;
        idle();
        reset = 1;
        step();
        step();
        reset = 0;

        // Idle after reset
        repeat (3) step();
        chk("reset_epc", EPC, 32'h0);
        chk("reset_masked", 32'(IrqMasked), 32'h0);

        // Load-use stall deferring a taken branch
        LoadUse = 1; ID_Branch = 1; BranchTaken = 1;
        step();
        LoadUse = 0;
        step();
        step();
        idle();
        step();

        // Irq blocked by a jump, taken next cycle
        Irq = 1; ID_Jump = 1; ID_PC = 32'h0000_0040;
        step();
        ID_Jump = 0; ID_PC = 32'h0000_0100;
        step();
        chk("irq_epc", EPC, 32'h0000_0100);
        chk("irq_masked", 32'(IrqMasked), 32'h1);

        // In KERNEL: Exc and Irq ignored, then eret and immediate re-entry
        Exc = 1; ID_PC = 32'h0000_0300;
        step();
        Exc = 0;
        step();
        chk("kernel_epc_hold", EPC, 32'h0000_0100);
        Eret = 1;
        step();
        chk("eret_unmasked", 32'(IrqMasked), 32'h0);
        Eret = 0; ID_PC = 32'h0000_0500;
        step();
        chk("reentry_epc", EPC, 32'h0000_0500);
        Irq = 0; Eret = 1;
        step();
        idle();

        // Exception with Irq present, then EPC wrap
        Exc = 1; Irq = 1; ID_PC = 32'h0000_0200;
        step();
        chk("exc_epc", EPC, 32'h0000_0204);
        idle(); Eret = 1;
        step();
        idle(); Exc = 1; ID_PC = 32'hFFFF_FFFC;
        step();
        chk("exc_wrap_epc", EPC, 32'h0000_0000);
        idle(); Eret = 1;
        step();
        idle();

        // Reset while in IRQ_WAIT
        Irq = 1; ID_Jump = 1; ID_PC = 32'h0000_0040;
        step();
        idle(); reset = 1;
        step();
        reset = 0;
        step();
        chk("rst_wait_masked", 32'(IrqMasked), 32'h0);

        // Reset while the stall counter is mid-count
        LoadUse = 1;
        step();
        LoadUse = 0; reset = 1;
        step();
        reset = 0;
        step();
        step();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(0, 79) == 0);
            Irq         = ($urandom_range(0, 3) == 0);
            Exc         = ($urandom_range(0, 9) == 0);
            Eret        = ($urandom_range(0, 3) == 0);
            LoadUse     = ($urandom_range(0, 4) == 0);
            ID_Branch   = ($urandom_range(0, 3) == 0);
            BranchTaken = ($urandom_range(0, 1) == 0);
            ID_Jump     = ($urandom_range(0, 5) == 0);
            ID_JR       = ($urandom_range(0, 7) == 0);
            PC_Kernel   = ($urandom_range(0, 7) == 0);
            ID_PC       = $urandom;
            step();
        end
        idle(); reset = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
